// File: rtl/level_sensor_conditioner_pkg.sv
// Shared definitions for the tank-level sensor conditioner.
// Holds the legal {us,sc,fc} level patterns, the conditioner state encoding
// and a helper that tells whether a debounced pattern is physically possible.
package level_sensor_conditioner_pkg;

    // Legal tank levels as {us, sc, fc}: a higher contact can only be wet
    // when every contact below it is wet too.
    localparam logic [2:0] LEVEL_EMPTY = 3'b000;
    localparam logic [2:0] LEVEL_LOW   = 3'b001;
    localparam logic [2:0] LEVEL_MID   = 3'b011;
    localparam logic [2:0] LEVEL_FULL  = 3'b111;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    function automatic logic level_valid(input logic [2:0] pattern);
        return (pattern == LEVEL_EMPTY) || (pattern == LEVEL_LOW) ||
               (pattern == LEVEL_MID)   || (pattern == LEVEL_FULL);
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a consecutive-cycle debouncer for one contact.
// Ports: clock, reset (sync, active-low), raw (async contact in), stable (debounced out).
// A raw change held steady reaches stable on the (DEBOUNCE_CYCLES+2)th rising edge.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          synced;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            meta   <= 1'b0;
            synced <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
            // Any cycle where the synchronized bit agrees with the stable
            // value restarts the run, so short glitches never get through.
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/level_sensor_conditioner.sv
// Conditions the three raw tank contacts into clean fc/sc/us for the irrigation FSM.
// Ports: clock, reset (sync, active-low), fcRaw/scRaw/usRaw (async contacts), clearFault
// (operator ack); fc/sc/us (clean levels), ready, levelChange (1-cycle pulse), sensorFault (latched).
module level_sensor_conditioner
    import level_sensor_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FAULT_CYCLES    = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic fcRaw,
    input  logic scRaw,
    input  logic usRaw,
    input  logic clearFault,
    output logic fc,
    output logic sc,
    output logic us,
    output logic ready,
    output logic levelChange,
    output logic sensorFault
);

    // Settle period covers the synchronizer plus one full debounce window,
    // so the first RUN decision is made on genuinely debounced inputs.
    localparam int SW = $clog2(DEBOUNCE_CYCLES + 2) + 1;
    localparam int FW = $clog2(FAULT_CYCLES) + 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(DEBOUNCE_CYCLES + 1);
    localparam logic [FW-1:0] FAULT_LAST  = FW'(FAULT_CYCLES - 1);
    localparam logic [FW-1:0] FAULT_TERM  = FW'(FAULT_CYCLES);

    logic [2:0]    pattern;     // debounced {us, sc, fc}
    logic          valid;
    state_t        state, state_nxt;
    logic [SW-1:0] settle_cnt, settle_nxt;
    logic [FW-1:0] fault_cnt, fault_nxt;
    logic [2:0]    level, level_nxt;
    logic          ready_nxt;
    logic          flag_nxt;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fc (
        .clock (clock), .reset (reset), .raw (fcRaw), .stable (pattern[0])
    );
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sc (
        .clock (clock), .reset (reset), .raw (scRaw), .stable (pattern[1])
    );
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_us (
        .clock (clock), .reset (reset), .raw (usRaw), .stable (pattern[2])
    );

    assign valid = level_valid(pattern);

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        fault_nxt  = fault_cnt;
        level_nxt  = level;
        ready_nxt  = ready;
        flag_nxt   = sensorFault;
        case (state)
            INIT: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = RUN;
                    ready_nxt = 1'b1;
                    if (valid) begin
                        level_nxt = pattern;
                    end
                end else begin
                    settle_nxt = settle_cnt + 1'b1;
                end
            end
            RUN: begin
                if (valid) begin
                    level_nxt = pattern;
                    fault_nxt = '0;
                end else if (fault_cnt == FAULT_LAST) begin
                    // This edge is the FAULT_CYCLES-th consecutive implausible one.
                    state_nxt = FAULT;
                    flag_nxt  = 1'b1;
                    fault_nxt = FAULT_TERM;
                end else begin
                    fault_nxt = fault_cnt + 1'b1;
                end
            end
            FAULT: begin
                // Acknowledge is only honoured once the contacts agree again.
                if (clearFault && valid) begin
                    state_nxt = RUN;
                    flag_nxt  = 1'b0;
                    fault_nxt = '0;
                    level_nxt = pattern;
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= INIT;
            settle_cnt  <= '0;
            fault_cnt   <= '0;
            level       <= LEVEL_EMPTY;
            ready       <= 1'b0;
            sensorFault <= 1'b0;
            levelChange <= 1'b0;
        end else begin
            state       <= state_nxt;
            settle_cnt  <= settle_nxt;
            fault_cnt   <= fault_nxt;
            level       <= level_nxt;
            ready       <= ready_nxt;
            sensorFault <= flag_nxt;
            levelChange <= (level_nxt != level);
        end
    end

    assign {us, sc, fc} = level;

endmodule
